// File: rtl/half_full_adder_pkg.sv
// Shared constants for the small arithmetic leaf blocks.
package half_full_adder_pkg;

    localparam int MAX_WIDTH = 64;

endpackage : half_full_adder_pkg

// File: rtl/half_full_adder_cell.sv
// One-bit full adder cell; the ripple chain in half_full_adder is built from these.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic prop;

    assign prop = a ^ b;
    assign s    = prop ^ cin;
    assign cout = (a & b) | (cin & prop);

endmodule : full_adder_cell

// File: rtl/half_full_adder.sv
// WIDTH-bit ripple adder, switchable between half (a+b) and full (a+b+cin) mode,
// with an optional one-stage registered output and valid flag.
module half_full_adder
    import half_full_adder_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    input  logic             cin,
    input  logic             full_en,
    input  logic             in_valid,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("half_full_adder: WIDTH out of range");
        end
    endgenerate

    // Half-adder mode is just the full chain with its carry-in forced low.
    assign carry[0] = full_en & cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
            full_adder_cell u_cell (
                .a    (a[gi]),
                .b    (b[gi]),
                .cin  (carry[gi]),
                .s    (sum_next[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] sum_reg;
            logic             cout_reg;
            logic             valid_reg;

            // Result registers load only on in_valid, so idle (possibly X) operands never reach them.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_reg   <= '0;
                    cout_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= in_valid;
                    if (in_valid) begin
                        sum_reg  <= sum_next;
                        cout_reg <= carry[WIDTH];
                    end
                end
            end

            assign sum       = sum_reg;
            assign cout      = cout_reg;
            assign out_valid = valid_reg;
        end else begin : g_comb
            assign sum       = sum_next;
            assign cout      = carry[WIDTH];
            assign out_valid = in_valid;
        end
    endgenerate

endmodule : half_full_adder

// File: tb/tb_half_full_adder.sv
// Directed-vector bench: 1-bit registered, 8-bit registered and 1-bit combinational adders.
module tb_half_full_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // 1-bit registered instance
    logic a1, b1, cin1, fe1, iv1, cout1, sum1, ov1;
    // 8-bit registered instance
    logic [7:0] a8, b8, sum8;
    logic cin8, fe8, iv8, cout8, ov8;
    // 1-bit combinational instance
    logic ac, bc, cinc, fec, ivc, coutc, sumc, ovc;

    half_full_adder #(.WIDTH(1), .REGISTERED(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cout(cout1), .sum(sum1),
        .cin(cin1), .full_en(fe1), .in_valid(iv1), .out_valid(ov1)
    );

    half_full_adder #(.WIDTH(8), .REGISTERED(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cout(cout8), .sum(sum8),
        .cin(cin8), .full_en(fe8), .in_valid(iv8), .out_valid(ov8)
    );

    half_full_adder #(.WIDTH(1), .REGISTERED(1'b0)) u_dutc (
        .clk(1'b0), .rst(1'b0), .a(ac), .b(bc), .cout(coutc), .sum(sumc),
        .cin(cinc), .full_en(fec), .in_valid(ivc), .out_valid(ovc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] ha_a_tab, ha_b_tab, ha_s_tab, ha_c_tab;
    logic [7:0] fa_s_tab, fa_c_tab;
    logic [3:0] cm_a_tab, cm_b_tab, cm_s_tab, cm_c_tab;

    initial begin
        // (a,b) = 00,01,10,11 -> sum 0,1,1,0 ; cout 0,0,0,1   (index = bit position)
        ha_a_tab = 4'b1100; ha_b_tab = 4'b1010;
        ha_s_tab = 4'b0110; ha_c_tab = 4'b1000;
        // index = {a,b,cin}: sum 0,1,1,0,1,0,0,1 ; cout 0,0,0,1,0,1,1,1
        fa_s_tab = 8'b1001_0110; fa_c_tab = 8'b1110_1000;
        // combinational sequence (a,b) = 00,10,01,11 -> sum 0,1,1,0 ; cout 0,0,0,1
        cm_a_tab = 4'b1010; cm_b_tab = 4'b1100;
        cm_s_tab = 4'b0110; cm_c_tab = 4'b1000;

        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; fe1 = 1'b0; iv1 = 1'b1;
        a8 = '0; b8 = '0; cin8 = 1'b0; fe8 = 1'b0; iv8 = 1'b0;
        ac = 1'b0; bc = 1'b0; cinc = 1'b0; fec = 1'b0; ivc = 1'b0;

        // Reset dominates in_valid for two cycles
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("rst%0d_sum", i), 64'(sum1), 64'd0);
            check($sformatf("rst%0d_cout", i), 64'(cout1), 64'd0);
            check($sformatf("rst%0d_ov", i), 64'(ov1), 64'd0);
        end
        check("rst_ov8", 64'(ov8), 64'd0);
        rst = 1'b0;
        step();
        check("rel_sum", 64'(sum1), 64'd0);
        check("rel_cout", 64'(cout1), 64'd1);
        check("rel_ov", 64'(ov1), 64'd1);

        // Half-adder truth table, back to back
        for (int i = 0; i < 4; i++) begin
            a1 = ha_a_tab[i]; b1 = ha_b_tab[i]; cin1 = 1'b0; fe1 = 1'b0; iv1 = 1'b1;
            step();
            check($sformatf("ha%0d_sum", i), 64'(sum1), 64'(ha_s_tab[i]));
            check($sformatf("ha%0d_cout", i), 64'(cout1), 64'(ha_c_tab[i]));
            check($sformatf("ha%0d_ov", i), 64'(ov1), 64'd1);
        end

        // Full-adder sweep
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; fe1 = 1'b1; iv1 = 1'b1;
            step();
            check($sformatf("fa%0d_sum", i), 64'(sum1), 64'(fa_s_tab[i]));
            check($sformatf("fa%0d_cout", i), 64'(cout1), 64'(fa_c_tab[i]));
        end

        // cin ignored in half mode: 1+1 (+1 ignored) = sum 0, cout 1
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; fe1 = 1'b0; iv1 = 1'b1;
        step();
        check("cin_ign_sum", 64'(sum1), 64'd0);
        check("cin_ign_cout", 64'(cout1), 64'd1);

        // Hold: idle operands (including X) must not disturb the result
        a1 = 1'bx; b1 = 1'b0; cin1 = 1'bx; fe1 = 1'b1; iv1 = 1'b0;
        step();
        check("hold_sum", 64'(sum1), 64'd0);
        check("hold_cout", 64'(cout1), 64'd1);
        check("hold_ov", 64'(ov1), 64'd0);
        step();
        check("hold2_cout", 64'(cout1), 64'd1);

        // Reset together with a valid operand drops it
        a1 = 1'b1; b1 = 1'b0; fe1 = 1'b0; iv1 = 1'b1; rst = 1'b1;
        step();
        check("rstv_sum", 64'(sum1), 64'd0);
        check("rstv_ov", 64'(ov1), 64'd0);
        rst = 1'b0; iv1 = 1'b0;

        // 8-bit wrap cases
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; fe8 = 1'b0; iv8 = 1'b1;
        step();
        check("w8a_sum", 64'(sum8), 64'h00);
        check("w8a_cout", 64'(cout8), 64'd1);
        check("w8a_ov", 64'(ov8), 64'd1);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; fe8 = 1'b1;
        step();
        check("w8b_sum", 64'(sum8), 64'hFF);
        check("w8b_cout", 64'(cout8), 64'd1);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1; fe8 = 1'b1;
        step();
        check("w8c_sum", 64'(sum8), 64'h97);
        check("w8c_cout", 64'(cout8), 64'd0);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; fe8 = 1'b1;
        step();
        check("w8d_sum", 64'(sum8), 64'h00);
        check("w8d_cout", 64'(cout8), 64'd1);
        a8 = 8'h12; b8 = 8'h34; iv8 = 1'b0;
        step();
        check("w8h_sum", 64'(sum8), 64'h00);
        check("w8h_ov", 64'(ov8), 64'd0);

        // Combinational instance: a toggles every 10 ns, b every 20 ns
        ivc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ac = cm_a_tab[i]; bc = cm_b_tab[i];
            #1;
            check($sformatf("cm%0d_sum", i), 64'(sumc), 64'(cm_s_tab[i]));
            check($sformatf("cm%0d_cout", i), 64'(coutc), 64'(cm_c_tab[i]));
            check($sformatf("cm%0d_ov", i), 64'(ovc), 64'd1);
            #9;
        end
        ivc = 1'b0; fec = 1'b1; cinc = 1'b1; ac = 1'b1; bc = 1'b0;
        #1;
        check("cm_fa_sum", 64'(sumc), 64'd0);
        check("cm_fa_cout", 64'(coutc), 64'd1);
        check("cm_ov0", 64'(ovc), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_half_full_adder

// File: doc/half_full_adder.md
# half_full_adder

Single-clock WIDTH-bit binary adder. It operates as a half adder (a+b) or a full adder (a+b+cin), selected at run time. Sum and carry-out are registered behind a one-stage valid pipeline. It is the basic arithmetic leaf used by larger datapath blocks. With the default WIDTH=1 and full_en=0 it is exactly a registered 1-bit half adder.

## Interface
Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.

Parameters:
- WIDTH, default 1, operand and sum width in bits (legal range 1..64).
- REGISTERED, default 1. 1 gives registered outputs with latency 1. 0 gives purely combinational outputs with latency 0.

Ports (required positional order after clk/rst is a, b, cout, sum, then the rest):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned
- cout  out  1  carry out of the MSB
- sum  out  WIDTH  a + b (+ cin), modulo 2^WIDTH
- cin  in  1  carry in; ignored unless full_en=1
- full_en  in  1  0 selects half-adder mode (carry-in forced 0); 1 selects full-adder mode
- in_valid  in  1  operands valid this cycle
- out_valid  out  1  sum/cout hold a freshly computed result

## Operation
- Effective carry-in: c0 = full_en & cin.
- Computation: {cout, sum} = a + b + c0, as a (WIDTH+1)-bit result. There is no truncation other than the MSB going to cout.
- Carry chain: ripple of WIDTH one-bit cells. For bit i:
  - s_i = a_i ^ b_i ^ c_i
  - c_{i+1} = a_i&b_i | c_i&(a_i^b_i)
  - cout = c_WIDTH.
- For WIDTH=1 with full_en=0: sum = a^b and cout = a&b. The results are:
  - 00 gives sum 0, cout 0
  - 01 and 10 give sum 1, cout 0
  - 11 gives sum 0, cout 1.
- Behaviour with REGISTERED=1:
  - When in_valid=1 at a rising edge, sum and cout load the result and out_valid becomes 1.
  - When in_valid=0, sum and cout hold their previous values and out_valid becomes 0.
- Behaviour with REGISTERED=0:
  - sum and cout follow the inputs combinationally.
  - out_valid = in_valid.
  - clk and rst are unused.
- X/Z on inputs while in_valid=0 must not disturb the registered outputs.

## Timing
- Reset (REGISTERED=1): at a rising edge with rst=1, sum, cout and out_valid all become 0. Reset takes priority over in_valid.
- Latency: 1 cycle from an in_valid=1 edge to the result on the outputs. Throughput is 1 result per cycle with no stall and no backpressure.
- Back-to-back valid cycles each produce a result on the following cycle.
- Reset in the same cycle as in_valid=1: that operand is dropped, and outputs are 0 on the next cycle.
- Release from reset: the first in_valid edge after rst deasserts produces a result one cycle later.
- Wrap-around: an all-ones a plus all-ones b with c0=1 gives sum = all-ones and cout = 1.
- Changes to full_en or cin take effect on the same edge as the operands they accompany.

## Structure
- Sub-module `full_adder_cell` (a, b, cin, s, cout), instantiated WIDTH times in a generate loop. Half-adder mode comes from tying the chain carry-in to 0 through c0, not from a separate cell.
- Shared package items: none required. A package constant for the maximum WIDTH (64) is optional if other arithmetic blocks share it.
- The output register stage is wrapped in a generate on REGISTERED.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1 and a=b=1 -> sum=0, cout=0, out_valid=0 throughout. After release, sum=0, cout=1 one cycle later.
- Half-adder truth table (WIDTH=1, full_en=0): (a,b) = 00, 01, 10, 11 on consecutive valid cycles -> (cout,sum) = 00, 01, 01, 10, each one cycle after its operands.
- Full-adder mode (WIDTH=1, full_en=1): sweep all 8 (a,b,cin) combinations.
  - cin=1 with a=b=1 -> sum=1, cout=1.
  - cin=1 with full_en=0 -> cin is ignored.
- Wide wrap (WIDTH=8): a=0xFF, b=0x01, full_en=0 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1, full_en=1 -> sum=0xFF, cout=1.
- Hold/valid: a valid result, then in_valid=0 with new operands -> sum and cout unchanged, out_valid=0.
- REGISTERED=0: toggle a every 10 ns and b every 20 ns with no clock -> sum=a^b and cout=a&b with zero latency.
